// File: rtl/uart_pkg.sv
// uart_pkg: shared states, parity modes and frame-length helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  // frame length in bit periods
  function automatic int frame_len(int data_bits, int parity, int stop_bits);
    return 1 + data_bits + (parity != PAR_NONE ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake between producer and transmitter
interface uart_tx_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts CLKS_PER_BIT cycles per serial bit and pulses bit_done on the last one
module uart_bit_timer #(parameter int CLKS_PER_BIT = 414) (
  input  logic CLKIN,
  input  logic RESET,
  input  logic clear,
  input  logic en,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_done = en && cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge CLKIN)
    if (RESET || clear) cnt <= '0;
    else if (en) cnt <= bit_done ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, start + LSB-first data + optional parity + stop bits
module uart_tx_param import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 414,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic CLKIN,
  input  logic RESET,
  uart_tx_param_if.slave bus,
  output logic out,
  output logic busy
);
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $fatal(1, "uart_tx_param: illegal parameter value");
  end
  state_t state;
  logic [DATA_BITS-1:0] shift;
  logic [3:0] bits;
  logic par;
  logic bit_done;
  logic last;
  logic accept;
  // last cycle of the final stop bit doubles as an accept slot for gapless frames
  assign last = bit_done && state == STOP && bits == 4'(STOP_BITS - 1);
  assign bus.ready = !RESET && (state == IDLE || last);
  assign accept = bus.valid && bus.ready;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
    .CLKIN(CLKIN),
    .RESET(RESET),
    .clear(accept),
    .en(state != IDLE),
    .bit_done(bit_done)
  );
  always_ff @(posedge CLKIN)
    if (RESET) begin
      state <= IDLE;
      out <= 1'b1;
      busy <= 1'b0;
      bits <= '0;
      shift <= '0;
      par <= 1'b0;
    end else if (accept) begin
      state <= START;
      out <= 1'b0;
      busy <= 1'b1;
      bits <= '0;
      shift <= bus.data;
      par <= ^bus.data ^ (PARITY == PAR_ODD);
    end else if (bit_done)
      case (state)
        START: begin
          state <= DATA;
          out <= shift[0];
        end
        DATA:
          if (bits == 4'(DATA_BITS - 1)) begin
            bits <= '0;
            state <= PARITY != PAR_NONE ? PAR : STOP;
            out <= PARITY != PAR_NONE ? par : 1'b1;
          end else begin
            bits <= bits + 4'd1;
            shift <= shift >> 1;
            out <= shift[1];
          end
        PAR: begin
          state <= STOP;
          out <= 1'b1;
        end
        STOP:
          if (last) begin
            state <= IDLE;
            busy <= 1'b0;
            bits <= '0;
          end else bits <= bits + 4'd1;
        default: state <= IDLE;
      endcase
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed-rate baud toggler.
- Serialises one data word per valid/ready handshake into a standard asynchronous frame: start bit, data bits LSB first, optional parity bit, 1 or 2 stop bits.
- The bit period is a compile-time clock-count divisor.
- Sits between a byte-producing core (FIFO or host logic) and the physical TX pin.

Parameters:
CLKS_PER_BIT, 414, CLKIN cycles per serial bit; legal range 2 or more.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
CLKIN  input  1  sole clock; all logic on its rising edge.
RESET  input  1  synchronous, active-high reset.
data   input  DATA_BITS  word to transmit; sampled only on accept.
valid  input  1  producer has a word on data.
ready  output 1  transmitter can accept a word this cycle.
out    output 1  serial line; idles high.
busy   output 1  high while a frame is in progress (START..STOP).

Behaviour:
- Clock and reset: one clock, CLKIN. RESET is synchronous and active-high.
- Reset values: out=1, busy=0, state=IDLE, bit counter=0, shift register=0.
- ready is forced to 0 in any cycle where RESET is high.
- States: IDLE, START, DATA, PAR, STOP.
- Accept: valid&&ready at a rising edge latches data into the shift register and computes the parity bit. The state goes to START on that edge.
- Latency: out goes 0 on the cycle after accept.
- Bit timing: every bit, including start, parity and stop, holds out for exactly CLKS_PER_BIT cycles. The counter has width clog2(CLKS_PER_BIT), runs 0..CLKS_PER_BIT-1 and wraps to 0 on bit_done.
- START -> DATA on bit_done.
- DATA shifts right on each bit_done; out = shift[0]. After DATA_BITS bits it goes to PAR if PARITY!=0, otherwise to STOP.
- Parity bit:
  - even: XOR of data.
  - odd: inverted XOR of data.
- PAR -> STOP on bit_done.
- STOP: out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- ready is high in IDLE.
- ready is also high in the final cycle of the last stop bit. This allows gapless back-to-back frames: an accept in that cycle goes straight to START. It is the only accept that happens outside IDLE.
- valid while busy, outside that final cycle: ignored. The data input has no effect on the frame in flight.
- busy=1 in START, DATA, PAR and STOP; busy=0 in IDLE.
- RESET mid-frame: the frame is aborted. On the next cycle out=1 and busy=0. No partial frame resumes.
- An illegal parameter value halts elaboration via an assertion.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP);
  - parity constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - helper function frame_len(DATA_BITS, PARITY, STOP_BITS).
- One sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT; inputs CLKIN, RESET, clear, en;
  - output bit_done, a 1-cycle pulse when the count reaches CLKS_PER_BIT-1;
  - clear restarts the count at 0 and is asserted on accept.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, send 0xA5 -> out holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total). busy high throughout. ready returns in the last stop cycle.
2. CLKS_PER_BIT=4, 8E1 and 8O1, send 0x07 -> parity bit is 1 (even) and 0 (odd) respectively, at cycles 36..39 after start. Frame is 44 cycles.
3. CLKS_PER_BIT=4, 8N1, valid held high with 0x00 then 0xFF -> second start bit begins exactly 40 cycles after the first. No idle-high gap. Exactly two accepts.
4. CLKS_PER_BIT=4, 8N2 -> stop phase lasts 8 cycles; frame is 44 cycles.
5. RESET pulsed at cycle 13 of a 0x00 frame -> out=1 and busy=0 on the next edge. ready=0 during RESET and 1 after. A new 0x55 frame then transmits correctly.
6. Default parameters, send 0x41 with data changed to 0xFF mid-frame -> each bit lasts 414 cycles. The transmitted word is still 0x41: bits 1,0,0,0,0,0,1,0 LSB first.
